// File: rtl/card_pkg.sv
// card_pkg: shared state type and pixel-format constants for the corner capture path.
package card_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DRAIN,
      DONE
   } state_t;

   // RGB565 pixel; green occupies bits [10:5]
   localparam int PIXEL_W   = 16;
   localparam int GREEN_LSB = 5;
   localparam int GREEN_MSB = 10;

endpackage

// File: rtl/corner_writer_valid_delay.sv
// valid_delay: fixed-depth shift register that tracks which frame-BRAM reads are
// still in flight, so the write side knows when returned data is valid.
module valid_delay #(
   parameter int DEPTH = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_valid,
   output logic o_valid,
   output logic o_busy
);

   logic [DEPTH-1:0] r_stages;

   // Shift a read-issued flag through one stage per clock
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stages <= '0;
      end else begin
         r_stages <= {r_stages[DEPTH-2:0], i_valid};
      end
   end

   assign o_valid = r_stages[DEPTH-1];
   assign o_busy  = |r_stages;

endmodule

// File: rtl/corner_writer.sv
// corner_writer: turns the corner address stream into frame-BRAM reads and packs the
// returned pixels contiguously into the corner buffer, reporting count and errors.
// Optional feature macro: CORNER_STATS_EN enables the dark-pixel counter.
module corner_writer #(
   parameter int         HEIGHT       = 320,
   parameter int         WIDTH        = 240,
   parameter int         PIXEL_W      = card_pkg::PIXEL_W,
   parameter int         BRAM_LATENCY = 2,
   parameter int         BUF_DEPTH    = 4096,
   parameter logic [5:0] DARK_THRESH  = 6'd20
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic [$clog2(HEIGHT*WIDTH)-1:0]  addr_in,
   input  logic                             addr_valid_in,
   input  logic [$clog2(WIDTH)-1:0]         corner_width,
   input  logic [$clog2(HEIGHT)-1:0]        corner_height,
   output logic [$clog2(HEIGHT*WIDTH)-1:0]  fb_addr_out,
   input  logic [PIXEL_W-1:0]               fb_data_in,
   output logic [$clog2(BUF_DEPTH)-1:0]     buf_addr_out,
   output logic [PIXEL_W-1:0]               buf_data_out,
   output logic                             buf_we_out,
   output logic                             busy_out,
   output logic                             done_out,
   output logic [$clog2(BUF_DEPTH):0]       pixel_count_out,
   output logic                             error_out,
   output logic [$clog2(BUF_DEPTH):0]       dark_count_out
);

   import card_pkg::*;

   localparam int AW         = $clog2(HEIGHT*WIDTH);
   localparam int BAW        = $clog2(BUF_DEPTH);
   localparam int CNTW       = BAW + 1;
   localparam int EXPW       = BAW + 2;
   localparam int PIPE_DEPTH = 1 + BRAM_LATENCY;

   state_t            r_state;
   logic [AW-1:0]     r_fb_addr;
   logic [EXPW-1:0]   r_expected;
   logic              r_error;
   logic              r_busy;
   logic              r_done;
   logic [CNTW-1:0]   r_pixel_count;
   logic [BAW-1:0]    r_wr_ptr;
   logic [CNTW-1:0]   r_count;
   logic              r_full;

   logic              w_accept;
   logic              w_pipe_valid;
   logic              w_pipe_any;
   logic              w_we;
   logic              w_dropped;
   logic              w_region_done;
   logic              w_burst_start;
   logic [EXPW-1:0]   w_cw_ext;
   logic [EXPW-1:0]   w_ch_ext;
   logic [EXPW-1:0]   w_expected;

   // Reads are only issued while a region is opening or being captured
   assign w_accept      = addr_valid_in && ((r_state == IDLE) || (r_state == CAPTURE));
   assign w_burst_start = (r_state == IDLE) && addr_valid_in;
   assign w_region_done = (r_state == DRAIN) && !w_pipe_any;

   // Oversized widths are truncated to the expected-count width before multiplying
   assign w_cw_ext   = EXPW'(corner_width) + EXPW'(1);
   assign w_ch_ext   = EXPW'(corner_height) + EXPW'(1);
   assign w_expected = w_cw_ext * w_ch_ext;

   // Once the last buffer slot has been written, later pixels are dropped
   assign w_we      = w_pipe_valid && !r_full;
   assign w_dropped = w_pipe_valid && r_full;

   valid_delay #(
      .DEPTH (PIPE_DEPTH)
   ) u_valid_delay (
      .i_clk   (clk_in),
      .i_rst_n (rst_in),
      .i_valid (w_accept),
      .o_valid (w_pipe_valid),
      .o_busy  (w_pipe_any)
   );

   // Capture the read address for every accepted generator cycle
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_fb_addr <= '0;
      end else if (w_accept) begin
         r_fb_addr <= addr_in;
      end
   end

   // Region control FSM with registered busy/done/error/count outputs
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state       <= IDLE;
         r_expected    <= '0;
         r_error       <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_pixel_count <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (addr_valid_in) begin
                  r_state    <= CAPTURE;
                  r_busy     <= 1'b1;
                  r_expected <= w_expected;
                  r_error    <= 1'b0;
               end
            end
            CAPTURE: begin
               if (!addr_valid_in) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (addr_valid_in) begin
                  r_error <= 1'b1;
               end
               if (!w_pipe_any) begin
                  r_state       <= DONE;
                  r_busy        <= 1'b0;
                  r_done        <= 1'b1;
                  r_pixel_count <= r_count;
                  if (EXPW'(r_count) != r_expected) begin
                     r_error <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (addr_valid_in) begin
                  r_error <= 1'b1;
               end
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
         if (w_dropped) begin
            r_error <= 1'b1;
         end
      end
   end

   // Write pointer and write count; the pointer parks on the last slot when full
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else if (w_burst_start) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else if (w_we) begin
         r_count <= r_count + CNTW'(1);
         if (r_wr_ptr == BAW'(BUF_DEPTH - 1)) begin
            r_full <= 1'b1;
         end else begin
            r_wr_ptr <= r_wr_ptr + BAW'(1);
         end
      end
   end

`ifdef CORNER_STATS_EN
   logic [CNTW-1:0] r_dark_acc;
   logic [CNTW-1:0] r_dark_count;
   logic            w_is_dark;

   assign w_is_dark = fb_data_in[GREEN_MSB:GREEN_LSB] < DARK_THRESH;

   // Count dark pixels among those actually written, publish at region end
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_dark_acc   <= '0;
         r_dark_count <= '0;
      end else begin
         if (w_burst_start) begin
            r_dark_acc <= '0;
         end else if (w_we && w_is_dark) begin
            r_dark_acc <= r_dark_acc + CNTW'(1);
         end
         if (w_region_done) begin
            r_dark_count <= r_dark_acc;
         end
      end
   end

   assign dark_count_out = r_dark_count;
`else
   assign dark_count_out = '0;
`endif

   assign fb_addr_out     = r_fb_addr;
   assign buf_addr_out    = r_wr_ptr;
   assign buf_we_out      = w_we;
   assign buf_data_out    = w_we ? fb_data_in : '0;
   assign busy_out        = r_busy;
   assign done_out        = r_done;
   assign pixel_count_out = r_pixel_count;
   assign error_out       = r_error;

endmodule

// File: tb/tb_corner_writer.sv
// tb_corner_writer: table-driven bench for corner_writer. Four instances share the
// generator stimulus: default (latency 2), latency 1, latency 3 and a 4-entry buffer.
module tb_corner_writer;

   typedef struct {
      int cw;
      int ch;
      int n;
      int base;
      int expCount;
      int expErr;
      int expDark;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [16:0] addr_in;
   logic        addr_valid_in;
   logic [7:0]  cw_in;
   logic [8:0]  ch_in;

   logic [15:0] mem [0:63];

   // default instance
   logic [16:0] m_fb_addr;
   logic [15:0] m_fb_data, m_p1, m_buf_data;
   logic [11:0] m_buf_addr;
   logic        m_we, m_busy, m_done, m_error;
   logic [12:0] m_pix, m_dark;
   // latency 1 instance
   logic [16:0] a_fb_addr;
   logic [15:0] a_fb_data, a_buf_data;
   logic [11:0] a_buf_addr;
   logic        a_we, a_busy, a_done, a_error;
   logic [12:0] a_pix, a_dark;
   // latency 3 instance
   logic [16:0] b_fb_addr;
   logic [15:0] b_fb_data, b_p1, b_p2, b_buf_data;
   logic [11:0] b_buf_addr;
   logic        b_we, b_busy, b_done, b_error;
   logic [12:0] b_pix, b_dark;
   // 4-entry buffer instance
   logic [16:0] s_fb_addr;
   logic [15:0] s_fb_data, s_p1, s_buf_data;
   logic [1:0]  s_buf_addr;
   logic        s_we, s_busy, s_done, s_error;
   logic [2:0]  s_pix, s_dark;

   int cyc = 0;
   int nTests = 0;
   int nFail = 0;
   int darkOn = 0;

   int mWrN = 0, aWrN = 0, bWrN = 0, sWrN = 0;
   int mDoneN = 0, sDoneN = 0;
   int mStart, aStart, bStart, sStart, mDoneStart, sDoneStart;
   int validCyc;
   int mWrAddr [0:511];
   int mWrData [0:511];
   int mWrCyc  [0:511];
   int aWrCyc  [0:511];
   int bWrCyc  [0:511];
   int sWrAddr [0:511];

   vec_t vecs [0:4];

   always #5 clk = ~clk;

   corner_writer dut (
      .clk_in(clk), .rst_in(rst_n), .addr_in(addr_in), .addr_valid_in(addr_valid_in),
      .corner_width(cw_in), .corner_height(ch_in), .fb_addr_out(m_fb_addr),
      .fb_data_in(m_fb_data), .buf_addr_out(m_buf_addr), .buf_data_out(m_buf_data),
      .buf_we_out(m_we), .busy_out(m_busy), .done_out(m_done),
      .pixel_count_out(m_pix), .error_out(m_error), .dark_count_out(m_dark)
   );

   corner_writer #(.BRAM_LATENCY(1)) dutL1 (
      .clk_in(clk), .rst_in(rst_n), .addr_in(addr_in), .addr_valid_in(addr_valid_in),
      .corner_width(cw_in), .corner_height(ch_in), .fb_addr_out(a_fb_addr),
      .fb_data_in(a_fb_data), .buf_addr_out(a_buf_addr), .buf_data_out(a_buf_data),
      .buf_we_out(a_we), .busy_out(a_busy), .done_out(a_done),
      .pixel_count_out(a_pix), .error_out(a_error), .dark_count_out(a_dark)
   );

   corner_writer #(.BRAM_LATENCY(3)) dutL3 (
      .clk_in(clk), .rst_in(rst_n), .addr_in(addr_in), .addr_valid_in(addr_valid_in),
      .corner_width(cw_in), .corner_height(ch_in), .fb_addr_out(b_fb_addr),
      .fb_data_in(b_fb_data), .buf_addr_out(b_buf_addr), .buf_data_out(b_buf_data),
      .buf_we_out(b_we), .busy_out(b_busy), .done_out(b_done),
      .pixel_count_out(b_pix), .error_out(b_error), .dark_count_out(b_dark)
   );

   corner_writer #(.BUF_DEPTH(4)) dutSmall (
      .clk_in(clk), .rst_in(rst_n), .addr_in(addr_in), .addr_valid_in(addr_valid_in),
      .corner_width(cw_in), .corner_height(ch_in), .fb_addr_out(s_fb_addr),
      .fb_data_in(s_fb_data), .buf_addr_out(s_buf_addr), .buf_data_out(s_buf_data),
      .buf_we_out(s_we), .busy_out(s_busy), .done_out(s_done),
      .pixel_count_out(s_pix), .error_out(s_error), .dark_count_out(s_dark)
   );

   // Frame-BRAM models with the read latency each instance is built for
   always_ff @(posedge clk) begin
      m_p1      <= mem[m_fb_addr[5:0]];
      m_fb_data <= m_p1;
      a_fb_data <= mem[a_fb_addr[5:0]];
      b_p1      <= mem[b_fb_addr[5:0]];
      b_p2      <= b_p1;
      b_fb_data <= b_p2;
      s_p1      <= mem[s_fb_addr[5:0]];
      s_fb_data <= s_p1;
   end

   // Free-running cycle counter used for latency measurement
   always_ff @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Record every buffer write and done pulse, sampled away from the active edge
   always_ff @(negedge clk) begin
      if (m_we && mWrN < 512) begin
         mWrAddr[mWrN] <= int'(m_buf_addr);
         mWrData[mWrN] <= int'(m_buf_data);
         mWrCyc[mWrN]  <= cyc;
         mWrN          <= mWrN + 1;
      end
      if (a_we && aWrN < 512) begin
         aWrCyc[aWrN] <= cyc;
         aWrN         <= aWrN + 1;
      end
      if (b_we && bWrN < 512) begin
         bWrCyc[bWrN] <= cyc;
         bWrN         <= bWrN + 1;
      end
      if (s_we && sWrN < 512) begin
         sWrAddr[sWrN] <= int'(s_buf_addr);
         sWrN          <= sWrN + 1;
      end
      if (m_done) mDoneN <= mDoneN + 1;
      if (s_done) sDoneN <= sDoneN + 1;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic snapshot();
      mStart     = mWrN;
      aStart     = aWrN;
      bStart     = bWrN;
      sStart     = sWrN;
      mDoneStart = mDoneN;
      sDoneStart = sDoneN;
   endtask

   // Drive one burst of n consecutive addresses, then let every instance finish
   task automatic applyStimulus(input int cw, input int ch, input int n, input int base);
      snapshot();
      @(negedge clk);
      cw_in    = 8'(cw);
      ch_in    = 9'(ch);
      validCyc = cyc;
      for (int k = 0; k < n; k++) begin
         addr_in       = 17'(base + k);
         addr_valid_in = 1'b1;
         @(negedge clk);
      end
      addr_valid_in = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   task automatic runVector(input int idx);
      vec_t v;
      int   sN;
      int   sErr;
      v = vecs[idx];
      applyStimulus(v.cw, v.ch, v.n, v.base);
      // default instance: full region written in raster order
      checkOutput("done_pulses", mDoneN - mDoneStart, 1);
      checkOutput("pixel_count", int'(m_pix), v.expCount);
      checkOutput("error", int'(m_error), v.expErr);
      checkOutput("dark_count", int'(m_dark), darkOn ? v.expDark : 0);
      checkOutput("busy_after", int'(m_busy), 0);
      checkOutput("write_num", mWrN - mStart, v.n);
      for (int j = 0; j < v.n; j++) begin
         checkOutput("wr_addr", mWrAddr[mStart + j], j);
         checkOutput("wr_data", mWrData[mStart + j], int'(mem[v.base + j]));
      end
      // first write lands 1+BRAM_LATENCY cycles after the first valid cycle
      if (mWrN > mStart) checkOutput("latency_L2", mWrCyc[mStart] - validCyc, 3);
      else               checkOutput("latency_L2_nowrite", 0, 1);
      if (aWrN > aStart) checkOutput("latency_L1", aWrCyc[aStart] - validCyc, 2);
      else               checkOutput("latency_L1_nowrite", 0, 1);
      if (bWrN > bStart) checkOutput("latency_L3", bWrCyc[bStart] - validCyc, 4);
      else               checkOutput("latency_L3_nowrite", 0, 1);
      // 4-entry buffer: writes stop after the last slot, overflow is flagged
      sN   = (v.n > 4) ? 4 : v.n;
      sErr = (v.expErr != 0 || v.n > 4) ? 1 : 0;
      checkOutput("small_done", sDoneN - sDoneStart, 1);
      checkOutput("small_writes", sWrN - sStart, sN);
      checkOutput("small_count", int'(s_pix), sN);
      checkOutput("small_error", int'(s_error), sErr);
      for (int j = 0; j < sN; j++) begin
         checkOutput("small_addr", sWrAddr[sStart + j], j);
      end
   endtask

   initial begin
`ifdef CORNER_STATS_EN
      darkOn = 1;
`endif
      // Pixels whose address is 1 mod 3 are dark (G=5), the rest bright (G=40)
      for (int i = 0; i < 64; i++) begin
         logic [5:0] g;
         g      = (i % 3 == 1) ? 6'd5 : 6'd40;
         mem[i] = {5'(i), g, ~5'(i)};
      end

      //            cw ch  n base cnt err dark
      vecs[0] = '{2, 1, 6, 0,  6, 0, 2};
      vecs[1] = '{2, 1, 5, 0,  5, 1, 2};
      vecs[2] = '{0, 2, 3, 20, 3, 0, 1};
      vecs[3] = '{3, 0, 4, 30, 4, 0, 1};
      vecs[4] = '{2, 1, 7, 40, 7, 1, 3};

      rst_n         = 1'b0;
      addr_in       = '0;
      addr_valid_in = 1'b0;
      cw_in         = '0;
      ch_in         = '0;
      #3;
      checkOutput("rst_we", int'(m_we), 0);
      checkOutput("rst_busy", int'(m_busy), 0);
      checkOutput("rst_done", int'(m_done), 0);
      checkOutput("rst_error", int'(m_error), 0);
      checkOutput("rst_count", int'(m_pix), 0);
      checkOutput("rst_fb_addr", int'(m_fb_addr), 0);
      checkOutput("rst_buf_addr", int'(m_buf_addr), 0);
      checkOutput("rst_dark", int'(m_dark), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         runVector(i);
      end

      // valid reasserted while draining is ignored and flagged
      snapshot();
      @(negedge clk);
      cw_in = 8'd2;
      ch_in = 9'd0;
      for (int k = 0; k < 3; k++) begin
         addr_in       = 17'(50 + k);
         addr_valid_in = 1'b1;
         @(negedge clk);
      end
      addr_valid_in = 1'b0;
      @(negedge clk);
      addr_in       = 17'd60;
      addr_valid_in = 1'b1;
      @(negedge clk);
      addr_valid_in = 1'b0;
      repeat (14) @(negedge clk);
      checkOutput("drain_done", mDoneN - mDoneStart, 1);
      checkOutput("drain_count", int'(m_pix), 3);
      checkOutput("drain_writes", mWrN - mStart, 3);
      checkOutput("drain_error", int'(m_error), 1);

      // reset in the middle of a capture burst, while a write is in progress
      snapshot();
      @(negedge clk);
      cw_in = 8'd2;
      ch_in = 9'd1;
      for (int k = 0; k < 3; k++) begin
         addr_in       = 17'(k);
         addr_valid_in = 1'b1;
         @(negedge clk);
      end
      checkOutput("pre_reset_we", int'(m_we), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_we", int'(m_we), 0);
      checkOutput("mid_rst_busy", int'(m_busy), 0);
      checkOutput("mid_rst_done", int'(m_done), 0);
      checkOutput("mid_rst_error", int'(m_error), 0);
      checkOutput("mid_rst_count", int'(m_pix), 0);
      checkOutput("mid_rst_fb_addr", int'(m_fb_addr), 0);
      checkOutput("mid_rst_buf_addr", int'(m_buf_addr), 0);
      checkOutput("mid_rst_buf_data", int'(m_buf_data), 0);
      addr_valid_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("abort_no_done", mDoneN - mDoneStart, 0);

      // a clean burst after the aborted one
      runVector(0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
